// File: rtl/conv_pkg.sv
// Shared definitions for the conv3x3 input path.
//  - calc_n / calc_idx_w : element count of a frame and the matching index width
//  - loader_state_t      : FILL/HOLD encoding of the input loader
//  - elem_offset         : bit offset of element idx in a flat tensor word
package conv_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } loader_state_t;

  function automatic int calc_n(input int b, input int c, input int h, input int w);
    return b * c * h * w;
  endfunction

  // A single-element frame still needs a 1-bit index.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int elem_offset(input int idx, input int dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/conv_input_loader_if.sv
// Bundle of the loader's pixel stream, tensor hand-off and status signals.
//  Pixel stream (valid/ready): a beat is in_valid & in_ready at a rising clk edge;
//  in_data/in_last are held by the source while in_valid is high and in_ready is low.
//  Tensor hand-off: input_tensor_flat is stable while tensor_valid is high; the consumer
//  pulses tensor_ack to release it.
//  master : pixel source / tensor consumer side
//  slave  : conv_input_loader side
//  state_dbg exposes the loader FSM state for observation.
interface conv_input_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16,
  parameter int CNT_WIDTH  = 16
);
  import conv_pkg::*;

  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic                    tensor_ack;
  logic [N*DATA_WIDTH-1:0] input_tensor_flat;
  logic                    tensor_valid;
  logic                    frame_err;
  logic [CNT_WIDTH-1:0]    frame_count;
  loader_state_t           state_dbg;

  modport master (
    output in_data, in_valid, in_last, tensor_ack,
    input  in_ready, input_tensor_flat, tensor_valid, frame_err, frame_count, state_dbg
  );

  modport slave (
    input  in_data, in_valid, in_last, tensor_ack,
    output in_ready, input_tensor_flat, tensor_valid, frame_err, frame_count, state_dbg
  );

endinterface

// File: rtl/conv_elem_counter.sv
// Element index counter for the input loader.
//  clk, rst : clock, async active-high reset
//  clr      : return idx to 0 (wins over inc)
//  inc      : advance idx by one
//  idx      : current element index 0..N-1
//  at_last  : idx == N-1
module conv_elem_counter #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             at_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + IDX_W'(1);
    end
  end

  assign at_last = (idx == IDX_W'(N - 1));

endmodule

// File: rtl/conv_input_loader.sv
// Collects a frame of N pixels from a valid/ready stream into a flat tensor word for
// conv3x3, then holds it with tensor_valid high until tensor_ack. A frame whose in_last
// does not coincide with element N-1 is dropped with a one-cycle frame_err pulse.
//  clk, rst : clock, async active-high reset
//  bus      : conv_input_loader_if slave modport (stream, tensor, status)
module conv_input_loader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BATCH_SIZE  = 1,
  parameter int IN_CHANNELS = 1,
  parameter int IN_HEIGHT   = 4,
  parameter int IN_WIDTH    = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic clk,
  input  logic rst,
  conv_input_loader_if.slave bus
);

  localparam int N     = calc_n(BATCH_SIZE, IN_CHANNELS, IN_HEIGHT, IN_WIDTH);
  localparam int IDX_W = calc_idx_w(N);

  loader_state_t           state;
  logic [IDX_W-1:0]        idx;
  logic                    at_last;
  logic                    beat;
  logic                    good_end;
  logic                    mismatch;
  logic                    cnt_inc;
  logic                    cnt_clr;
  logic [N-1:0]            wr_en;
  logic [N*DATA_WIDTH-1:0] tensor_q;
  logic                    tensor_valid_q;
  logic                    frame_err_q;
  logic [CNT_WIDTH-1:0]    frame_count_q;

  // Ready comes from the registered state only, so ack never reaches in_ready in the same cycle.
  assign bus.in_ready = (state == ST_FILL);

  always_comb begin
    beat     = bus.in_valid && (state == ST_FILL);
    good_end = beat && at_last && bus.in_last;
    cnt_inc  = beat && !at_last && !bus.in_last;
    // Any other beat is a length mismatch: last too early, or missing on element N-1.
    mismatch = beat && !cnt_inc && !good_end;
    cnt_clr  = mismatch || ((state == ST_HOLD) && bus.tensor_ack);
  end

  conv_elem_counter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .idx     (idx),
    .at_last (at_last)
  );

  // Every beat writes its element, including beats of a frame that later turns out malformed;
  // those elements are never exposed because tensor_valid stays low.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < N; i++) begin
      wr_en[i] = beat && (idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tensor_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en[i]) begin
          tensor_q[elem_offset(i, DATA_WIDTH) +: DATA_WIDTH] <= bus.in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_FILL;
      tensor_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state)
        ST_FILL: begin
          if (good_end) begin
            state          <= ST_HOLD;
            tensor_valid_q <= 1'b1;
          end else if (mismatch) begin
            frame_err_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.tensor_ack) begin
            state          <= ST_FILL;
            tensor_valid_q <= 1'b0;
            frame_count_q  <= frame_count_q + CNT_WIDTH'(1);
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign bus.input_tensor_flat = tensor_q;
  assign bus.tensor_valid      = tensor_valid_q;
  assign bus.frame_err         = frame_err_q;
  assign bus.frame_count       = frame_count_q;
  assign bus.state_dbg         = state;

endmodule

// File: tb/tb_conv_input_loader.sv
// Bench for conv_input_loader (4x4x1 frames, 32-bit elements).
module tb_conv_input_loader;
  import conv_pkg::*;

  localparam int DW = 32;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int N  = 16;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_input_loader_if #(.DATA_WIDTH(DW), .N(N), .CNT_WIDTH(CW)) bus();

  conv_input_loader #(
    .DATA_WIDTH (DW),
    .BATCH_SIZE (1),
    .IN_CHANNELS(1),
    .IN_HEIGHT  (H),
    .IN_WIDTH   (W),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_count = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*DW-1:0] exp_flat();
    logic [N*DW-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) e[i*DW +: DW] = exp_q[i];
    return e;
  endfunction

  // 3x3 all-ones kernel, zero padding, bias 0.
  function automatic int conv_at(input logic [N*DW-1:0] t, input int oy, input int ox);
    int s;
    s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (oy+dy >= 0 && oy+dy < H && ox+dx >= 0 && ox+dx < W)
          s += int'(t[((oy+dy)*W + (ox+dx))*DW +: DW]);
    return s;
  endfunction

  // ---------------- driver tasks (entered and left just after a falling edge) ----------------
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int waited;
    waited = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL beat_timeout: in_ready=%0b required 1", bus.in_ready);
      n_errors++;
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.tensor_ack = 1'b0;
    rst = 1'b1;
    exp_count = 0;
    exp_q.delete();
    #1;
    n_checks++;
    if (bus.tensor_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.frame_count !== '0 ||
        bus.input_tensor_flat !== '0 || bus.in_ready !== 1'b1) begin
      $display("FAIL reset_outputs: tv=%0b err=%0b cnt=%0d flat_nonzero=%0b rdy=%0b required 0,0,0,0,1",
               bus.tensor_valid, bus.frame_err, bus.frame_count, |bus.input_tensor_flat, bus.in_ready);
      n_errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Hold for d cycles with garbage offered on the stream, then acknowledge.
  task automatic hold_and_ack(input int d, input string name);
    logic [N*DW-1:0] e;
    e = exp_flat();
    for (int k = 0; k < d; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (bus.tensor_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.input_tensor_flat !== e) begin
        $display("FAIL %s_hold: tv=%0b rdy=%0b stable=%0b required 1,0,1",
                 name, bus.tensor_valid, bus.in_ready, bus.input_tensor_flat === e);
        n_errors++;
      end
    end
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.tensor_ack = 1'b1;
    @(negedge clk);
    bus.tensor_ack = 1'b0;
    exp_count++;
    exp_q.delete();
    n_checks++;
    if (bus.tensor_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.frame_count !== CW'(exp_count)) begin
      $display("FAIL %s_ack: tv=%0b rdy=%0b cnt=%0d required 0,1,%0d",
               name, bus.tensor_valid, bus.in_ready, bus.frame_count, exp_count);
      n_errors++;
    end
  endtask

  // Full clean frame of random data; optional random gaps between beats.
  task automatic send_clean_frame(input bit gaps, input string name);
    logic [DW-1:0] v;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      v = $urandom;
      exp_q.push_back(v);
      send_beat(v, i == N-1);
      n_checks++;
      if (bus.tensor_valid !== (i == N-1) || bus.frame_err !== 1'b0) begin
        $display("FAIL %s_beat%0d: tv=%0b err=%0b required %0b,0",
                 name, i, bus.tensor_valid, bus.frame_err, i == N-1);
        n_errors++;
      end
    end
    n_checks++;
    if (bus.input_tensor_flat !== exp_flat()) begin
      $display("FAIL %s_tensor: got %h required %h", name, bus.input_tensor_flat, exp_flat());
      n_errors++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst            = 1'b1;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.tensor_ack = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.tensor_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.frame_count !== '0 ||
        bus.input_tensor_flat !== '0 || bus.in_ready !== 1'b1) begin
      $display("FAIL reset_state: tv=%0b err=%0b cnt=%0d rdy=%0b required 0,0,0,1",
               bus.tensor_valid, bus.frame_err, bus.frame_count, bus.in_ready);
      n_errors++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp_frame();
    int c0, c5, c15;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(DW'(i));
      send_beat(DW'(i), i == N-1);
      if (i == N-2) begin
        n_checks++;
        if (bus.tensor_valid !== 1'b0) begin
          $display("FAIL ramp_early_valid: tv=%0b required 0", bus.tensor_valid);
          n_errors++;
        end
      end
    end
    n_checks++;
    if (bus.tensor_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      $display("FAIL ramp_latency: tv=%0b rdy=%0b required 1,0", bus.tensor_valid, bus.in_ready);
      n_errors++;
    end
    n_checks++;
    if (bus.input_tensor_flat !== exp_flat()) begin
      $display("FAIL ramp_tensor: got %h required %h", bus.input_tensor_flat, exp_flat());
      n_errors++;
    end
    c0  = conv_at(bus.input_tensor_flat, 0, 0);
    c5  = conv_at(bus.input_tensor_flat, 1, 1);
    c15 = conv_at(bus.input_tensor_flat, 3, 3);
    n_checks++;
    if (c0 != 10 || c5 != 45 || c15 != 50) begin
      $display("FAIL ramp_conv: out0=%0d out5=%0d out15=%0d required 10,45,50", c0, c5, c15);
      n_errors++;
    end
    hold_and_ack(3, "ramp");
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 10; i++) begin
      send_beat($urandom, i == 9);
      n_checks++;
      if (bus.frame_err !== (i == 9) || bus.tensor_valid !== 1'b0) begin
        $display("FAIL short_beat%0d: err=%0b tv=%0b required %0b,0",
                 i, bus.frame_err, bus.tensor_valid, i == 9);
        n_errors++;
      end
    end
    idle();
    n_checks++;
    if (bus.frame_err !== 1'b0 || bus.tensor_valid !== 1'b0) begin
      $display("FAIL short_pulse_end: err=%0b tv=%0b required 0,0", bus.frame_err, bus.tensor_valid);
      n_errors++;
    end
    send_clean_frame(1'b0, "short_next");
    hold_and_ack(0, "short_next");
  endtask

  task automatic test_long_frame();
    for (int i = 0; i < N; i++) begin
      send_beat($urandom, 1'b0);
      n_checks++;
      if (bus.frame_err !== (i == N-1) || bus.tensor_valid !== 1'b0) begin
        $display("FAIL long_beat%0d: err=%0b tv=%0b required %0b,0",
                 i, bus.frame_err, bus.tensor_valid, i == N-1);
        n_errors++;
      end
    end
    idle();
    n_checks++;
    if (bus.frame_err !== 1'b0 || bus.tensor_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL long_after: err=%0b tv=%0b rdy=%0b required 0,0,1",
               bus.frame_err, bus.tensor_valid, bus.in_ready);
      n_errors++;
    end
  endtask

  task automatic test_random_frames();
    apply_reset();
    for (int f = 0; f < 50; f++) begin
      send_clean_frame(1'b1, "rand");
      hold_and_ack($urandom_range(0, 20), "rand");
    end
    n_checks++;
    if (bus.frame_count !== CW'(50)) begin
      $display("FAIL rand_count: got %0d required 50", bus.frame_count);
      n_errors++;
    end
  endtask

  task automatic test_reset_cases();
    for (int i = 0; i < 7; i++) send_beat($urandom, 1'b0);
    apply_reset();
    send_clean_frame(1'b0, "rst_mid");
    hold_and_ack(2, "rst_mid");
    send_clean_frame(1'b0, "rst_hold_pre");
    apply_reset();
    send_clean_frame(1'b0, "rst_hold");
    hold_and_ack(1, "rst_hold");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ramp_frame();
    test_short_frame();
    test_long_frame();
    test_random_frames();
    test_reset_cases();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
